// File: rtl/cpu_sequencer_if.sv
// Program-memory fetch handshake between the instruction sequencer and memory.
// The master drives the request and address; the slave acks and returns data in the same cycle.
interface cpu_sequencer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int REG_WIDTH  = 8
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [REG_WIDTH-1:0]  mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Instruction-cycle controller: fetches opcode/immediate bytes, then drives one
// execute and one write-back cycle of ALU/mux/write-enable controls per instruction.
module cpu_sequencer #(
    parameter int                    REG_WIDTH  = 8,
    parameter int                    OPP_WIDTH  = 4,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cpu_sequencer_if.master      mem,
    input  logic                 go,
    output logic [OPP_WIDTH-1:0] alu_op,
    output logic [2:0]           sel_a,
    output logic [2:0]           sel_b,
    output logic [REG_WIDTH-1:0] imm,
    output logic                 we_add,
    output logic                 we_x,
    output logic                 we_y,
    output logic                 we_stat,
    output logic                 halted,
    output logic                 busy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_OP,
        S_FETCH_IMM,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [6:0]            op_q, op_d;
    logic [REG_WIDTH-1:0]  imm_q, imm_d;
    logic                  mem_req_q, mem_req_d;
    logic [OPP_WIDTH-1:0]  alu_op_q, alu_op_d;
    logic [2:0]            sel_a_q, sel_a_d;
    logic [2:0]            sel_b_q, sel_b_d;
    logic                  we_add_q, we_add_d;
    logic                  we_x_q, we_x_d;
    logic                  we_y_q, we_y_d;
    logic                  we_stat_q, we_stat_d;
    logic                  halted_q, halted_d;
    logic                  busy_q, busy_d;
    logic                  in_exec;
    logic                  in_wb;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        imm_d   = imm_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH_OP;
            S_FETCH_OP: begin
                if (mem.mem_ack) begin
                    op_d  = mem.mem_rdata[6:0];
                    imm_d = '0;
                    pc_d  = pc_q + ADDR_WIDTH'(1);
                    if (mem.mem_rdata == '0)
                        state_d = S_HALT;
                    else if (mem.mem_rdata[7])
                        state_d = S_FETCH_IMM;
                    else
                        state_d = S_EXEC;
                end
            end
            S_FETCH_IMM: begin
                if (mem.mem_ack) begin
                    imm_d   = mem.mem_rdata;
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = S_WB;
            S_WB:   state_d = S_FETCH_OP;
            S_HALT: if (go) state_d = S_FETCH_OP;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they land in flops and
        // carry no combinational path from mem_ack, mem_rdata or go.
        in_exec   = (state_d == S_EXEC) || (state_d == S_WB);
        in_wb     = (state_d == S_WB);
        mem_req_d = (state_d == S_FETCH_OP) || (state_d == S_FETCH_IMM);
        sel_a_d   = in_exec ? 3'd1 : 3'd0;
        sel_b_d   = in_exec ? (3'(op_d[1:0]) + 3'd1) : 3'd0;
        alu_op_d  = in_exec ? OPP_WIDTH'(op_d[6:4]) : '0;
        we_add_d  = in_wb && (op_d[3:2] == 2'b00);
        we_x_d    = in_wb && (op_d[3:2] == 2'b01);
        we_y_d    = in_wb && (op_d[3:2] == 2'b10);
        we_stat_d = in_wb;
        halted_d  = (state_d == S_HALT);
        busy_d    = !((state_d == S_IDLE) || (state_d == S_HALT));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            op_q      <= '0;
            imm_q     <= '0;
            mem_req_q <= 1'b0;
            alu_op_q  <= '0;
            sel_a_q   <= '0;
            sel_b_q   <= '0;
            we_add_q  <= 1'b0;
            we_x_q    <= 1'b0;
            we_y_q    <= 1'b0;
            we_stat_q <= 1'b0;
            halted_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            op_q      <= op_d;
            imm_q     <= imm_d;
            mem_req_q <= mem_req_d;
            alu_op_q  <= alu_op_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
            we_add_q  <= we_add_d;
            we_x_q    <= we_x_d;
            we_y_q    <= we_y_d;
            we_stat_q <= we_stat_d;
            halted_q  <= halted_d;
            busy_q    <= busy_d;
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = pc_q;
    assign alu_op       = alu_op_q;
    assign sel_a        = sel_a_q;
    assign sel_b        = sel_b_q;
    assign imm          = imm_q;
    assign we_add       = we_add_q;
    assign we_x         = we_x_q;
    assign we_y         = we_y_q;
    assign we_stat      = we_stat_q;
    assign halted       = halted_q;
    assign busy         = busy_q;
endmodule
